// File: rtl/ervp_button_event_pkg.sv
// Shared constants for the button event detector: event bit indices within a
// channel group and the per-channel FSM state encoding.
package ervp_button_event_pkg;

  localparam int unsigned EVENT_W      = 5;
  localparam int unsigned EVENT_PRESS  = 0;
  localparam int unsigned EVENT_RELEASE = 1;
  localparam int unsigned EVENT_CLICK  = 2;
  localparam int unsigned EVENT_LONG   = 3;
  localparam int unsigned EVENT_DOUBLE = 4;

  typedef enum logic [2:0] {
    StIdle       = 3'd0,
    StPressed    = 3'd1,
    StLongHeld   = 3'd2,
    StWaitSecond = 3'd3,
    StSecondHeld = 3'd4
  } btn_state_e;

endpackage

// File: rtl/ervp_button_event_fsm.sv
// Single-channel button event FSM with tick-based duration counter.
// Double-click states exist only when ERVP_BUTTON_DOUBLE_CLICK_EN is defined.
module ervp_button_event_fsm
  import ervp_button_event_pkg::*;
#(
  parameter int unsigned BW_TICK_COUNT      = 8,
  parameter int unsigned LONG_PRESS_TICKS   = 100,
  parameter int unsigned DOUBLE_CLICK_TICKS = 25
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_enable,
  input  logic               i_tick,
  input  logic               i_level,
  output logic [EVENT_W-1:0] o_pulse,
  output logic [EVENT_W-1:0] o_pulse_next
);

  localparam logic [BW_TICK_COUNT-1:0] LongTerm = BW_TICK_COUNT'(LONG_PRESS_TICKS - 1);
  localparam logic [BW_TICK_COUNT-1:0] DblTerm  = BW_TICK_COUNT'(DOUBLE_CLICK_TICKS - 1);

  if (LONG_PRESS_TICKS < 1 || LONG_PRESS_TICKS >= (1 << BW_TICK_COUNT)) begin : g_bad_long
    $error("LONG_PRESS_TICKS out of range");
  end
  if (DOUBLE_CLICK_TICKS < 1 || DOUBLE_CLICK_TICKS >= (1 << BW_TICK_COUNT)) begin : g_bad_dbl
    $error("DOUBLE_CLICK_TICKS out of range");
  end

  btn_state_e               r_state, w_state_d;
  logic [BW_TICK_COUNT-1:0] r_cnt, w_cnt_d;
  logic [EVENT_W-1:0]       r_pulse, w_pulse_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_pulse <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_pulse <= w_pulse_d;
    end
  end

  // A level change always takes precedence over a tick in the same cycle.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_pulse_d = '0;
    if (!i_enable) begin
      w_state_d = StIdle;
      w_cnt_d   = '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_level) begin
            w_state_d              = StPressed;
            w_cnt_d                = '0;
            w_pulse_d[EVENT_PRESS] = 1'b1;
          end
        end
        StPressed: begin
          if (!i_level) begin
            w_pulse_d[EVENT_RELEASE] = 1'b1;
            w_cnt_d                  = '0;
`ifdef ERVP_BUTTON_DOUBLE_CLICK_EN
            w_state_d                = StWaitSecond;
`else
            w_pulse_d[EVENT_CLICK]   = 1'b1;
            w_state_d                = StIdle;
`endif
          end else if (i_tick) begin
            if (r_cnt == LongTerm) begin
              w_state_d             = StLongHeld;
              w_pulse_d[EVENT_LONG] = 1'b1;
            end else begin
              w_cnt_d = r_cnt + BW_TICK_COUNT'(1);
            end
          end
        end
        StLongHeld: begin
          if (!i_level) begin
            w_state_d                = StIdle;
            w_cnt_d                  = '0;
            w_pulse_d[EVENT_RELEASE] = 1'b1;
          end
        end
`ifdef ERVP_BUTTON_DOUBLE_CLICK_EN
        StWaitSecond: begin
          if (i_level) begin
            w_state_d               = StSecondHeld;
            w_cnt_d                 = '0;
            w_pulse_d[EVENT_PRESS]  = 1'b1;
            w_pulse_d[EVENT_DOUBLE] = 1'b1;
          end else if (i_tick) begin
            if (r_cnt == DblTerm) begin
              w_state_d              = StIdle;
              w_cnt_d                = '0;
              w_pulse_d[EVENT_CLICK] = 1'b1;
            end else begin
              w_cnt_d = r_cnt + BW_TICK_COUNT'(1);
            end
          end
        end
        StSecondHeld: begin
          if (!i_level) begin
            w_state_d                = StIdle;
            w_cnt_d                  = '0;
            w_pulse_d[EVENT_RELEASE] = 1'b1;
          end
        end
`endif
        default: begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
        end
      endcase
    end
  end

  assign o_pulse      = r_pulse;
  assign o_pulse_next = w_pulse_d;

endmodule

// File: rtl/ervp_button_event_detector.sv
// Button event detector: per-channel event FSMs, sticky W1C status and
// maskable irq. Optional double-click via ERVP_BUTTON_DOUBLE_CLICK_EN.
module ervp_button_event_detector
  import ervp_button_event_pkg::*;
#(
  parameter int unsigned BW_DATA            = 1,
  parameter int unsigned BW_TICK_COUNT      = 8,
  parameter int unsigned LONG_PRESS_TICKS   = 100,
  parameter int unsigned DOUBLE_CLICK_TICKS = 25
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_enable,
  input  logic                       i_tick,
  input  logic [BW_DATA-1:0]         i_input_debounced,
  output logic [EVENT_W*BW_DATA-1:0] o_event_pulse,
  output logic [EVENT_W*BW_DATA-1:0] o_status,
  input  logic [EVENT_W*BW_DATA-1:0] i_status_clear,
  input  logic [EVENT_W*BW_DATA-1:0] i_irq_mask,
  output logic                       o_irq
);

  logic [EVENT_W*BW_DATA-1:0] w_pulse_next;
  logic [EVENT_W*BW_DATA-1:0] r_status;

  for (genvar c = 0; c < BW_DATA; c++) begin : g_chan
    ervp_button_event_fsm #(
      .BW_TICK_COUNT      (BW_TICK_COUNT),
      .LONG_PRESS_TICKS   (LONG_PRESS_TICKS),
      .DOUBLE_CLICK_TICKS (DOUBLE_CLICK_TICKS)
    ) u_fsm (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_enable     (i_enable),
      .i_tick       (i_tick),
      .i_level      (i_input_debounced[c]),
      .o_pulse      (o_event_pulse[EVENT_W*c +: EVENT_W]),
      .o_pulse_next (w_pulse_next[EVENT_W*c +: EVENT_W])
    );
  end

  // Status sets in the same cycle the pulse appears; a set beats a clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_status <= '0;
    end else begin
      r_status <= (r_status & ~i_status_clear) | w_pulse_next;
    end
  end

  assign o_status = r_status;
  assign o_irq    = |(r_status & i_irq_mask);

endmodule
